// File: rtl/eq_band_mixer_pkg.sv
// Shared constants and FSM state type for the equalizer band mixer.
// Used by eq_band_mixer, its interface and the eq_round_sat stage.
package eq_pkg;

    localparam int N_BANDS    = 8;
    localparam int BAND_IDX_W = 3;
    localparam int IN_W       = 32;
    localparam int FRAC_IN    = 14;
    localparam int GAIN_W     = 12;
    localparam int OUT_W      = 16;
    localparam int ACC_W      = 48;
    localparam int PROD_W     = IN_W + GAIN_W + 1;
    localparam int SHIFT      = FRAC_IN + 8;

    localparam logic [GAIN_W-1:0] UNITY_GAIN = 12'h100;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/eq_band_mixer_if.sv
// Sample, gain-write and result signals between the band filters and the mixer.
interface eq_band_mixer_if;
    import eq_pkg::*;

    logic                      ena;
    logic                      in_valid;
    logic [N_BANDS*IN_W-1:0]   band_in;
    logic                      in_ready;
    logic                      gain_we;
    logic [BAND_IDX_W-1:0]     gain_addr;
    logic [GAIN_W-1:0]         gain_wdata;
    logic signed [OUT_W-1:0]   y_out;
    logic                      out_valid;
    logic                      sat_flag;
    logic                      overrun;

    modport master (
        output ena, in_valid, band_in, gain_we, gain_addr, gain_wdata,
        input  in_ready, y_out, out_valid, sat_flag, overrun
    );

    modport slave (
        input  ena, in_valid, band_in, gain_we, gain_addr, gain_wdata,
        output in_ready, y_out, out_valid, sat_flag, overrun
    );

endinterface

// File: rtl/eq_band_mixer_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation from an
// accumulator down to an output sample, with a clip indicator.
module eq_round_sat
    import eq_pkg::*;
#(
    parameter int A_W = ACC_W,
    parameter int O_W = OUT_W,
    parameter int SH  = SHIFT
) (
    input  logic signed [A_W-1:0] acc,
    output logic signed [O_W-1:0] y,
    output logic                  clip
);

    localparam logic signed [A_W-1:0] HALF  = A_W'(1) <<< (SH - 1);
    localparam logic signed [A_W-1:0] Y_MAX = (A_W'(1) <<< (O_W - 1)) - A_W'(1);
    localparam logic signed [A_W-1:0] Y_MIN = -(A_W'(1) <<< (O_W - 1));

    logic signed [A_W-1:0] biased;
    logic signed [A_W-1:0] shifted;

    always_comb begin
        biased  = acc + HALF;
        shifted = biased >>> SH;
        y       = shifted[O_W-1:0];
        clip    = 1'b0;
        if (shifted > Y_MAX) begin
            y    = Y_MAX[O_W-1:0];
            clip = 1'b1;
        end else if (shifted < Y_MIN) begin
            y    = Y_MIN[O_W-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// Weights 8 band-filter outputs by per-band Q4.8 gains with one shared MAC,
// then rounds/saturates to a 16-bit sample. Optional EQ_MIX_SAT_CNT_EN adds sat_count.
module eq_band_mixer
    import eq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    eq_band_mixer_if.slave  bus
`ifdef EQ_MIX_SAT_CNT_EN
    ,
    output logic [15:0]     sat_count
`endif
);

    state_t state, state_next;

    logic [BAND_IDX_W-1:0]    band_idx;
    logic signed [IN_W-1:0]   band_hold   [N_BANDS];
    logic [GAIN_W-1:0]        gain_shadow [N_BANDS];
    logic [GAIN_W-1:0]        gain_active [N_BANDS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  y_rs;
    logic signed [OUT_W-1:0]  y_reg;
    logic                     clip_rs;
    logic                     out_valid_reg;
    logic                     sat_reg;
    logic                     overrun_reg;
    logic                     in_ready_c;
    logic                     start;
    logic                     busy_hit;
    logic                     acc_en;
    logic                     out_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.ena && bus.in_valid) state_next = ACC;
            ACC:  if (band_idx == BAND_IDX_W'(N_BANDS - 1)) state_next = OUT;
            OUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        start      = 1'b0;
        busy_hit   = bus.ena & bus.in_valid;
        acc_en     = 1'b0;
        out_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                start      = bus.ena & bus.in_valid;
                busy_hit   = 1'b0;
            end
            ACC:     acc_en = 1'b1;
            OUT:     out_en = 1'b1;
            default: ;
        endcase
    end

    // The 1'b0 prefix keeps the unsigned Q4.8 gain positive in the signed multiply.
    assign prod = PROD_W'(band_hold[band_idx]) *
                  PROD_W'($signed({1'b0, gain_active[band_idx]}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BANDS; i++) gain_shadow[i] <= UNITY_GAIN;
        end else if (bus.gain_we) begin
            gain_shadow[bus.gain_addr] <= bus.gain_wdata;
        end
    end

    // Active gains are latched only at capture so a sample's weights stay fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BANDS; i++) begin
                band_hold[i]   <= '0;
                gain_active[i] <= UNITY_GAIN;
            end
            acc      <= '0;
            band_idx <= '0;
        end else if (start) begin
            for (int i = 0; i < N_BANDS; i++) begin
                band_hold[i]   <= bus.band_in[i*IN_W +: IN_W];
                gain_active[i] <= gain_shadow[i];
            end
            acc      <= '0;
            band_idx <= '0;
        end else if (acc_en) begin
            acc      <= acc + ACC_W'(prod);
            band_idx <= band_idx + 1'b1;
        end
    end

    eq_round_sat u_round_sat (
        .acc  (acc),
        .y    (y_rs),
        .clip (clip_rs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= out_en;
            sat_reg       <= out_en & clip_rs;
            if (out_en)   y_reg       <= y_rs;
            if (busy_hit) overrun_reg <= 1'b1;
        end
    end

`ifdef EQ_MIX_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_count <= '0;
        else if (out_en && clip_rs && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.y_out     = y_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sat_flag  = sat_reg;
    assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed table-driven bench for eq_band_mixer plus hand-written corner sequences.
// Define EQ_MIX_SAT_CNT_EN to also check the saturation counter.
module tb_eq_band_mixer;
    import eq_pkg::*;

    localparam int SCALE = 16384;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    eq_band_mixer_if bus();

`ifdef EQ_MIX_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    eq_band_mixer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EQ_MIX_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string                   name;
        logic [N_BANDS*IN_W-1:0] bands;
        int                      gain_band;
        logic [GAIN_W-1:0]       gain;
        int                      exp_y;
        int                      exp_sat;
    } vec_t;

    vec_t vecs[13];
    int total = 0;
    int bad   = 0;
    int exp_sat_cnt = 0;

    function automatic logic [N_BANDS*IN_W-1:0] one_band(int idx, int val);
        logic [N_BANDS*IN_W-1:0] v;
        v = '0;
        v[idx*IN_W +: IN_W] = val;
        return v;
    endfunction

    function automatic logic [N_BANDS*IN_W-1:0] all_bands(int val);
        logic [N_BANDS*IN_W-1:0] v;
        for (int i = 0; i < N_BANDS; i++) v[i*IN_W +: IN_W] = val;
        return v;
    endfunction

    function automatic vec_t mk(string n, logic [N_BANDS*IN_W-1:0] b, int gb,
                                logic [GAIN_W-1:0] g, int y, int s);
        vec_t v;
        v.name = n; v.bands = b; v.gain_band = gb; v.gain = g; v.exp_y = y; v.exp_sat = s;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic write_gain(input int addr, input logic [GAIN_W-1:0] val);
        @(negedge clk);
        bus.gain_we    = 1'b1;
        bus.gain_addr  = BAND_IDX_W'(addr);
        bus.gain_wdata = val;
        @(negedge clk);
        bus.gain_we    = 1'b0;
    endtask

    task automatic set_gains(input int band, input logic [GAIN_W-1:0] g);
        for (int i = 0; i < N_BANDS; i++) write_gain(i, UNITY_GAIN);
        write_gain(band, g);
    endtask

    // Waits (bounded) on negedges for out_valid; n = -1 on timeout.
    task automatic wait_out(output int y, output int sat, output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.out_valid !== 1'b1) n = -1;
        y   = int'($signed(bus.y_out));
        sat = int'(bus.sat_flag);
    endtask

    task automatic capture(input logic [N_BANDS*IN_W-1:0] bands);
        @(negedge clk);
        bus.band_in  = bands;
        bus.ena      = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [N_BANDS*IN_W-1:0] bands,
                                 output int y, output int sat, output int lat);
        int n;
        capture(bands);
        wait_out(y, sat, n);
        lat = (n < 0) ? -1 : n + 1;
    endtask

    task automatic count_pulses(input int cycles, output int pulses, output int last_y);
        pulses = 0;
        last_y = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                pulses++;
                last_y = int'($signed(bus.y_out));
            end
        end
    endtask

    initial begin
        int y, sat, lat, n, pulses, not_ready;

        bus.ena = 1'b0; bus.in_valid = 1'b0; bus.band_in = '0;
        bus.gain_we = 1'b0; bus.gain_addr = '0; bus.gain_wdata = '0;

        vecs[0]  = mk("unity_1000",  one_band(0, 1000*SCALE), 0, UNITY_GAIN, 1000, 0);
        vecs[1]  = mk("round_pos",   one_band(0, 8192),       0, UNITY_GAIN, 1, 0);
        vecs[2]  = mk("round_half",  one_band(0, -8192),      0, UNITY_GAIN, 0, 0);
        vecs[3]  = mk("round_neg",   one_band(0, -8193),      0, UNITY_GAIN, -1, 0);
        vecs[4]  = mk("sat_pos",     all_bands(10000*SCALE),  0, UNITY_GAIN, 32767, 1);
        vecs[5]  = mk("sat_neg",     all_bands(-10000*SCALE), 0, UNITY_GAIN, -32768, 1);
        vecs[6]  = mk("gain_zero",   one_band(3, 500*SCALE),  3, 12'h000, 0, 0);
        vecs[7]  = mk("gain_half",   one_band(5, 1000*SCALE), 5, 12'h080, 500, 0);
        vecs[8]  = mk("mix_three",   one_band(0, 100*SCALE) | one_band(1, -300*SCALE)
                                     | one_band(7, 50*SCALE), 1, 12'h300, -750, 0);
        vecs[9]  = mk("gain_max",    one_band(2, 10*SCALE),   2, 12'hFFF, 160, 0);
        vecs[10] = mk("edge_max",    one_band(0, 32767*SCALE), 0, UNITY_GAIN, 32767, 0);
        vecs[11] = mk("clip_max",    one_band(0, 32768*SCALE), 0, UNITY_GAIN, 32767, 1);
        vecs[12] = mk("edge_min",    one_band(0, -32768*SCALE), 0, UNITY_GAIN, -32768, 0);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_y_out",     int'($signed(bus.y_out)), 0);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_sat_flag",  int'(bus.sat_flag), 0);
        checkOutput("rst_overrun",   int'(bus.overrun), 0);
        checkOutput("rst_in_ready",  int'(bus.in_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            set_gains(vecs[i].gain_band, vecs[i].gain);
            applyStimulus(vecs[i].bands, y, sat, lat);
            checkOutput($sformatf("%s_y", vecs[i].name), y, vecs[i].exp_y);
            checkOutput($sformatf("%s_sat", vecs[i].name), sat, vecs[i].exp_sat);
            checkOutput($sformatf("%s_latency", vecs[i].name), lat, 10);
            @(negedge clk);
            checkOutput($sformatf("%s_pulse_width", vecs[i].name), int'(bus.out_valid), 0);
            if (vecs[i].exp_sat != 0) exp_sat_cnt++;
        end
`ifdef EQ_MIX_SAT_CNT_EN
        checkOutput("sat_count", int'(sat_count), exp_sat_cnt);
`endif

        // Gain written mid-computation must not affect the running sample.
        set_gains(3, UNITY_GAIN);
        capture(one_band(3, 500*SCALE));
        checkOutput("busy_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.gain_we = 1'b1; bus.gain_addr = 3'd3; bus.gain_wdata = 12'h200;
        @(negedge clk);
        bus.gain_we = 1'b0;
        wait_out(y, sat, n);
        checkOutput("stage_a_seen", int'(n >= 0), 1);
        checkOutput("stage_a_y", y, 500);
        applyStimulus(one_band(3, 500*SCALE), y, sat, lat);
        checkOutput("stage_b_y", y, 1000);

        // Write and capture on the same edge: old shadow value applies.
        @(negedge clk);
        bus.band_in = one_band(3, 500*SCALE); bus.ena = 1'b1; bus.in_valid = 1'b1;
        bus.gain_we = 1'b1; bus.gain_addr = 3'd3; bus.gain_wdata = UNITY_GAIN;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.gain_we = 1'b0;
        wait_out(y, sat, n);
        checkOutput("same_edge_old_gain", y, 1000);
        applyStimulus(one_band(3, 500*SCALE), y, sat, lat);
        checkOutput("same_edge_new_gain", y, 500);
        repeat (3) @(negedge clk);
        checkOutput("y_hold", int'($signed(bus.y_out)), 500);

        // in_valid with ena low is ignored.
        @(negedge clk);
        bus.ena = 1'b0; bus.in_valid = 1'b1; bus.band_in = one_band(0, 1000*SCALE);
        pulses = 0; not_ready = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) pulses++;
            if (bus.in_ready !== 1'b1) not_ready++;
        end
        bus.in_valid = 1'b0; bus.ena = 1'b1;
        checkOutput("ena_low_pulses", pulses, 0);
        checkOutput("ena_low_not_ready", not_ready, 0);
        checkOutput("ena_low_y_hold", int'($signed(bus.y_out)), 500);
        checkOutput("ena_low_overrun", int'(bus.overrun), 0);

        // Input at capture+3 is dropped and flags overrun.
        capture(one_band(0, 1000*SCALE));
        @(negedge clk);
        bus.in_valid = 1'b1; bus.band_in = one_band(0, 2000*SCALE);
        @(negedge clk);
        bus.in_valid = 1'b0;
        count_pulses(25, pulses, y);
        checkOutput("overrun_pulses", pulses, 1);
        checkOutput("overrun_y", y, 1000);
        checkOutput("overrun_set", int'(bus.overrun), 1);
        applyStimulus(one_band(0, 2000*SCALE), y, sat, lat);
        checkOutput("after_overrun_y", y, 2000);
        checkOutput("overrun_sticky", int'(bus.overrun), 1);

        // Reset at capture+5 aborts the sample and restores unity gains.
        write_gain(0, 12'h200);
        capture(one_band(0, 1000*SCALE));
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_y_out",     int'($signed(bus.y_out)), 0);
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        checkOutput("abort_sat_flag",  int'(bus.sat_flag), 0);
        checkOutput("abort_overrun",   int'(bus.overrun), 0);
        checkOutput("abort_in_ready",  int'(bus.in_ready), 1);
`ifdef EQ_MIX_SAT_CNT_EN
        checkOutput("abort_sat_count", int'(sat_count), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_pulses(15, pulses, y);
        checkOutput("abort_no_pulse", pulses, 0);
        applyStimulus(one_band(0, 1000*SCALE), y, sat, lat);
        checkOutput("post_reset_unity_y", y, 1000);
        checkOutput("post_reset_latency", lat, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
